pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the stall and flush pins of the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves, by fixed priority: post-reset pipeline scrub, data-memory wait freeze, EX-stage control redirect (branch/jump), and load-use hazards.
- Also keeps saturating stall/flush performance counters and flags data-memory timeouts.

---
 rtl/pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage MIPS pipeline
module pipe_hazard_ctrl #(
    parameter int INIT_CYC    = 3,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_regread1,
    input  logic             id_regread2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             perf_clr,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int IW = (INIT_CYC > 2) ? $clog2(INIT_CYC) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CYC - 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_RUN     = 2'd1,
        S_MEMWAIT = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   init_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [WW-1:0]   wait_next;
    logic            load_use;
    logic            mem_hold;
    logic            freeze;
    logic            resolve;
    logic            redirect_apply;
    logic            stall_inc;

    // resolve marks cycles where redirect/load-use are evaluated: an
    // unfrozen RUN cycle or the release cycle of a memory wait.
    always_comb begin
        load_use  = ex_memread && (ex_rt != 5'd0) &&
                    ((id_regread1 && (id_rs == ex_rt)) ||
                     (id_regread2 && (id_rt == ex_rt)));
        mem_hold  = dmem_req && !dmem_ready;
        wait_next = wait_cnt + WW'(1);
        freeze    = 1'b0;
        resolve   = 1'b0;
        case (state)
            S_RUN: begin
                freeze  = mem_hold;
                resolve = !mem_hold;
            end
            S_MEMWAIT: begin
                freeze  = !dmem_ready;
                resolve = dmem_ready;
            end
            S_ERR:   freeze = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        if (state == S_INIT) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
        end else if (resolve) begin
            // A redirect squashes the ID instruction, so its load-use match is moot.
            if (ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    assign redirect_apply = resolve && ex_redirect;
    assign stall_inc      = pc_stall && ((state == S_RUN) || (state == S_MEMWAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        init_cnt <= '0;
                        state    <= S_RUN;
                    end else begin
                        init_cnt <= init_cnt + IW'(1);
                    end
                end
                S_RUN: begin
                    if (mem_hold) begin
                        wait_cnt <= WW'(1);
                        if (MEM_TIMEOUT <= 1) begin
                            mem_err <= 1'b1;
                            state   <= S_ERR;
                        end else begin
                            state <= S_MEMWAIT;
                        end
                    end
                end
                S_MEMWAIT: begin
                    // A release in the timeout cycle still wins.
                    if (dmem_ready) begin
                        wait_cnt <= '0;
                        state    <= S_RUN;
                    end else begin
                        wait_cnt <= wait_next;
                        if (wait_next == WAIT_LIMIT) begin
                            mem_err <= 1'b1;
                            state   <= S_ERR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect_apply && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_INIT = 6'b101010;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_RED  = 6'b001010;
    localparam logic [5:0] C_FRZ  = 6'b110101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_regread1 = 0, id_regread2 = 0, ex_memread = 0;
    logic       ex_redirect = 0, dmem_req = 0, dmem_ready = 0, perf_clr = 0;
    logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
    logic       mem_err;
    logic [3:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic [5:0] ctl;
        logic       err;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    pipe_hazard_ctrl #(.INIT_CYC(3), .MEM_TIMEOUT(6), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_regread1(id_regread1), .id_regread2(id_regread2),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_regread1 = 0; id_regread2 = 0; ex_memread = 0;
        ex_redirect = 0; dmem_req = 0; dmem_ready = 0; perf_clr = 0;
    endtask

    task automatic lu_rs();
        ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; id_regread1 = 1;
    endtask

    task automatic expect_out(input string nm, input logic [5:0] ctl, input logic err,
                              input int sc, input int fc);
        exp_t e;
        e.ctl = ctl; e.err = err; e.sc = 4'(sc); e.fc = 4'(fc);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are presented every cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            logic [5:0] act;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall};
            tests++;
            if (act !== e.ctl || mem_err !== e.err || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                fails++;
                $display("FAIL %s: got ctl=%b err=%b stall=%0d flush=%0d, want ctl=%b err=%b stall=%0d flush=%0d",
                         nm, act, mem_err, stall_cnt, flush_cnt, e.ctl, e.err, e.sc, e.fc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); expect_out("rst0", C_INIT, 0, 0, 0);
        tick(); ex_redirect = 1; dmem_req = 1; expect_out("rst_inputs", C_INIT, 0, 0, 0);
        tick(); rst_n = 1; ex_redirect = 1; expect_out("init0", C_INIT, 0, 0, 0);
        tick(); dmem_req = 1; expect_out("init1", C_INIT, 0, 0, 0);
        tick(); lu_rs(); expect_out("init2", C_INIT, 0, 0, 0);
        tick(); expect_out("run_idle", C_NONE, 0, 0, 0);

        tick(); lu_rs(); expect_out("lu_rs", C_LU, 0, 0, 0);
        tick(); expect_out("after_lu", C_NONE, 0, 1, 0);
        tick(); ex_memread = 1; id_regread1 = 1; expect_out("lu_r0", C_NONE, 0, 1, 0);
        tick(); ex_memread = 1; ex_rt = 5'd8; id_rt = 5'd8; id_regread2 = 1;
        expect_out("lu_rt", C_LU, 0, 1, 0);
        tick(); ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; expect_out("lu_noread", C_NONE, 0, 2, 0);
        tick(); ex_rt = 5'd8; id_rs = 5'd8; id_regread1 = 1; expect_out("not_load", C_NONE, 0, 2, 0);

        tick(); lu_rs(); ex_redirect = 1; expect_out("redir_lu", C_RED, 0, 2, 0);
        tick(); expect_out("after_redir", C_NONE, 0, 2, 1);

        for (int i = 0; i < 5; i++) begin
            tick(); dmem_req = 1; ex_redirect = 1; expect_out("memwait", C_FRZ, 0, 2 + i, 1);
        end
        tick(); dmem_req = 1; dmem_ready = 1; ex_redirect = 1; expect_out("release_tmo_edge", C_RED, 0, 7, 1);
        tick(); expect_out("after_release", C_NONE, 0, 7, 2);

        tick(); dmem_req = 1; dmem_ready = 1; expect_out("single_access", C_NONE, 0, 7, 2);
        tick(); expect_out("no_memwait", C_NONE, 0, 7, 2);

        tick(); dmem_req = 1; expect_out("wait1", C_FRZ, 0, 7, 2);
        tick(); dmem_req = 1; dmem_ready = 1; lu_rs(); expect_out("release_lu", C_LU, 0, 8, 2);
        tick(); expect_out("after_rel_lu", C_NONE, 0, 9, 2);

        tick(); lu_rs(); perf_clr = 1; expect_out("clr_with_inc", C_LU, 0, 9, 2);
        tick(); expect_out("after_clr", C_NONE, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            tick(); lu_rs(); expect_out("lu_sat", C_LU, 0, (i > 15) ? 15 : i, 0);
        end
        tick(); expect_out("sat_hold", C_NONE, 0, 15, 0);
        tick(); perf_clr = 1; expect_out("clr_idle", C_NONE, 0, 15, 0);
        tick(); expect_out("cleared", C_NONE, 0, 0, 0);

        tick(); dmem_req = 1; expect_out("mw_a", C_FRZ, 0, 0, 0);
        tick(); dmem_req = 1; expect_out("mw_b", C_FRZ, 0, 1, 0);
        tick(); dmem_req = 1; rst_n = 0; expect_out("rst_in_wait", C_INIT, 0, 0, 0);
        tick(); rst_n = 1; expect_out("reinit0", C_INIT, 0, 0, 0);
        tick(); expect_out("reinit1", C_INIT, 0, 0, 0);
        tick(); expect_out("reinit2", C_INIT, 0, 0, 0);
        tick(); expect_out("rerun", C_NONE, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            tick(); dmem_req = 1; expect_out("tmo_wait", C_FRZ, 0, i, 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); dmem_req = 1; expect_out("err_frz", C_FRZ, 1, 6, 0);
        end
        for (int i = 0; i < 2; i++) begin
            tick(); dmem_req = 1; dmem_ready = 1; ex_redirect = 1; lu_rs();
            expect_out("err_ignores_ready", C_FRZ, 1, 6, 0);
        end
        tick(); rst_n = 0; expect_out("err_rst", C_INIT, 0, 0, 0);
        tick(); rst_n = 1; expect_out("post_err_init0", C_INIT, 0, 0, 0);
        tick(); expect_out("post_err_init1", C_INIT, 0, 0, 0);
        tick(); expect_out("post_err_init2", C_INIT, 0, 0, 0);
        tick(); expect_out("post_err_run", C_NONE, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
